// File: rtl/fifo_interval_meter_pkg.sv
// fifo_meter_pkg: shared types and helpers for the interval meter.
//   meter_state_e : FSM state encoding (2'b11 is unused and recovers to IDLE)
//   sat_inc       : increment that sticks at the all-ones value of a given width
package fifo_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } meter_state_e;

    // Works on a 64-bit carrier so one function serves any counter width up to 64.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] lim;
        lim = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        return (val >= lim) ? lim : val + 64'd1;
    endfunction

endpackage

// File: rtl/fifo_interval_meter_if.sv
// fifo_interval_meter_if: measurement control and result handshake bundle.
//   meas_start, meas_stop, timeout_val, result_ack : producer -> meter
//   result_vld, result_cnt, result_tout, result_sat,
//   busy, lost_evt                                  : meter -> consumer
// master = the side driving the measurement, slave = the meter itself.
interface fifo_interval_meter_if #(parameter int unsigned CNT_W = 32);

    logic             meas_start;
    logic             meas_stop;
    logic [CNT_W-1:0] timeout_val;
    logic             result_ack;
    logic             result_vld;
    logic [CNT_W-1:0] result_cnt;
    logic             result_tout;
    logic             result_sat;
    logic             busy;
    logic             lost_evt;

    modport master (
        output meas_start, meas_stop, timeout_val, result_ack,
        input  result_vld, result_cnt, result_tout, result_sat, busy, lost_evt
    );

    modport slave (
        input  meas_start, meas_stop, timeout_val, result_ack,
        output result_vld, result_cnt, result_tout, result_sat, busy, lost_evt
    );

endinterface

// File: rtl/fifo_rise_det.sv
// fifo_rise_det: registered rising-edge detector.
//   cpu_clk, cpu_rst_b : clock, async active-low reset
//   sig_in             : level input
//   rise               : high while sig_in is high and was low at the previous edge
module fifo_rise_det (
    input  logic cpu_clk,
    input  logic cpu_rst_b,
    input  logic sig_in,
    output logic rise
);

    logic sig_ff;

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            sig_ff <= 1'b0;
        end else begin
            sig_ff <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_ff;

endmodule

// File: rtl/fifo_interval_meter.sv
// fifo_interval_meter: counts cpu_clk cycles from a start edge to a stop
// (or timeout) and hands the count out through a valid/ack handshake.
//   cpu_clk, cpu_rst_b : clock, async active-low reset
//   mif (slave)        : start/stop/timeout/ack in; result and status out
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a start edge; stop and ack ignored
// RUN   | counting; restart on start edge, capture on stop or timeout
// HOLD  | result held valid until ack; start edge without ack is lost
module fifo_interval_meter
    import fifo_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic             cpu_clk,
    input logic             cpu_rst_b,
    fifo_interval_meter_if.slave mif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_tout_q, res_tout_d;
    logic             res_sat_q, res_sat_d;
    logic             lost_q, lost_d;
    logic             start_edge;

    fifo_rise_det u_start_det (
        .cpu_clk   (cpu_clk),
        .cpu_rst_b (cpu_rst_b),
        .sig_in    (mif.meas_start),
        .rise      (start_edge)
    );

    assign cnt_next = CNT_W'(sat_inc(64'(cnt_q), CNT_W));

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            res_cnt_q  <= '0;
            res_tout_q <= 1'b0;
            res_sat_q  <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_cnt_q  <= res_cnt_d;
            res_tout_q <= res_tout_d;
            res_sat_q  <= res_sat_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_cnt_d  = res_cnt_q;
        res_tout_d = res_tout_q;
        res_sat_d  = res_sat_q;
        lost_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (start_edge) begin
                    cnt_d = '0;
                end else if (mif.meas_stop ||
                             ((mif.timeout_val != '0) && (cnt_next == mif.timeout_val))) begin
                    // Stop outranks a coincident timeout, so tout only when stop is low.
                    state_d    = HOLD;
                    res_cnt_d  = cnt_next;
                    res_tout_d = ~mif.meas_stop;
                    res_sat_d  = (cnt_q == CNT_MAX) || (cnt_next == CNT_MAX);
                end else begin
                    cnt_d = cnt_next;
                end
            end
            HOLD: begin
                if (mif.result_ack && start_edge) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (mif.result_ack) begin
                    state_d = IDLE;
                end else if (start_edge) begin
                    lost_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mif.result_vld  = (state_q == HOLD);
    assign mif.busy        = (state_q == RUN);
    assign mif.result_cnt  = res_cnt_q;
    assign mif.result_tout = res_tout_q;
    assign mif.result_sat  = res_sat_q;
    assign mif.lost_evt    = lost_q;

endmodule

// File: tb/tb_fifo_interval_meter.sv
// tb_fifo_interval_meter: directed bench for fifo_interval_meter.
// A 32-bit meter is checked every cycle against a timestamp-based model;
// a 4-bit meter shares the stimulus and is checked for saturation.
module tb_fifo_interval_meter;

    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    logic cpu_clk = 1'b0;
    logic cpu_rst_b = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    fifo_interval_meter_if #(.CNT_W(32)) mif ();
    fifo_interval_meter_if #(.CNT_W(4))  mif4 ();

    fifo_interval_meter #(.CNT_W(32)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_b (cpu_rst_b),
        .mif       (mif)
    );

    fifo_interval_meter #(.CNT_W(4)) dut4 (
        .cpu_clk   (cpu_clk),
        .cpu_rst_b (cpu_rst_b),
        .mif       (mif4)
    );

    assign mif4.meas_start  = mif.meas_start;
    assign mif4.meas_stop   = mif.meas_stop;
    assign mif4.result_ack  = mif.result_ack;
    assign mif4.timeout_val = mif.timeout_val[3:0];

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: remembers the edge index at which the current measurement
    // started; the result is simply the number of edges elapsed, capped.
    int     m_mode  = 0;    // 0 waiting, 1 measuring, 2 holding
    bit     m_prev  = 1'b0;
    longint m_cyc   = 0;
    longint m_t0    = 0;
    longint m_cnt   = 0;
    bit     m_tout  = 1'b0;
    bit     m_sat   = 1'b0;
    bit     m_lost  = 1'b0;

    always @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            m_mode <= 0;
            m_prev <= 1'b0;
            m_cyc  <= 0;
            m_t0   <= 0;
            m_cnt  <= 0;
            m_tout <= 1'b0;
            m_sat  <= 1'b0;
            m_lost <= 1'b0;
        end else begin : model_step
            bit     edge_s;
            longint elapsed;
            longint capped;
            edge_s  = mif.meas_start && !m_prev;
            elapsed = m_cyc - m_t0;
            capped  = (elapsed > MAX32) ? MAX32 : elapsed;
            m_prev  <= mif.meas_start;
            m_cyc   <= m_cyc + 1;
            m_lost  <= 1'b0;
            if (m_mode == 0) begin
                if (edge_s) begin
                    m_mode <= 1;
                    m_t0   <= m_cyc;
                end
            end else if (m_mode == 1) begin
                if (edge_s) begin
                    m_t0 <= m_cyc;
                end else if (mif.meas_stop) begin
                    m_mode <= 2;
                    m_cnt  <= capped;
                    m_tout <= 1'b0;
                    m_sat  <= (elapsed >= MAX32);
                end else if (mif.timeout_val != 0 && capped == longint'(mif.timeout_val)) begin
                    m_mode <= 2;
                    m_cnt  <= capped;
                    m_tout <= 1'b1;
                    m_sat  <= (elapsed >= MAX32);
                end
            end else begin
                if (mif.result_ack && edge_s) begin
                    m_mode <= 1;
                    m_t0   <= m_cyc;
                end else if (mif.result_ack) begin
                    m_mode <= 0;
                end else if (edge_s) begin
                    m_lost <= 1'b1;
                end
            end
        end
    end

    always @(negedge cpu_clk) begin
        chk("vld",  64'(mif.result_vld),  64'(m_mode == 2));
        chk("busy", 64'(mif.busy),        64'(m_mode == 1));
        chk("lost", 64'(mif.lost_evt),    64'(m_lost));
        chk("cnt",  64'(mif.result_cnt),  64'(m_cnt));
        chk("tout", 64'(mif.result_tout), 64'(m_tout));
        chk("sat",  64'(mif.result_sat),  64'(m_sat));
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge cpu_clk);
        #2;
    endtask

    task automatic ack_result();
        mif.result_ack = 1'b1;
        cyc_wait(1);
        mif.result_ack = 1'b0;
        chk("ack_vld_low", 64'(mif.result_vld), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.meas_start  = 1'b0;
        mif.meas_stop   = 1'b0;
        mif.result_ack  = 1'b0;
        mif.timeout_val = '0;
        cyc_wait(3);
        chk("rst_vld",  64'(mif.result_vld), 64'd0);
        chk("rst_busy", 64'(mif.busy),       64'd0);
        chk("rst_cnt",  64'(mif.result_cnt), 64'd0);
        cpu_rst_b = 1'b1;
        cyc_wait(2);

        // ack while idle is ignored
        mif.result_ack = 1'b1;
        cyc_wait(1);
        mif.result_ack = 1'b0;
        chk("idle_ack_vld", 64'(mif.result_vld), 64'd0);

        // basic: N = 5
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        chk("basic_busy", 64'(mif.busy), 64'd1);
        cyc_wait(4);
        mif.meas_stop = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("basic_vld",  64'(mif.result_vld),  64'd1);
        chk("basic_cnt",  64'(mif.result_cnt),  64'd5);
        chk("basic_tout", 64'(mif.result_tout), 64'd0);
        chk("model_basic_cnt", 64'(m_cnt), 64'd5);
        cyc_wait(2);
        ack_result();
        chk("basic_keep_cnt", 64'(mif.result_cnt), 64'd5);

        // timeout at 8
        mif.timeout_val = 32'd8;
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(7);
        chk("tout_pre_busy", 64'(mif.busy), 64'd1);
        cyc_wait(1);
        chk("tout_vld",  64'(mif.result_vld),  64'd1);
        chk("tout_cnt",  64'(mif.result_cnt),  64'd8);
        chk("tout_flag", 64'(mif.result_tout), 64'd1);
        ack_result();

        // stop coincides with timeout: stop wins
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(7);
        mif.meas_stop = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("tout_stop_cnt",  64'(mif.result_cnt),  64'd8);
        chk("tout_stop_flag", 64'(mif.result_tout), 64'd0);
        ack_result();
        mif.timeout_val = '0;

        // restart: second edge 3 cycles later, stop 4 after it
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(2);
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(3);
        chk("restart_no_vld", 64'(mif.result_vld), 64'd0);
        mif.meas_stop = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("restart_cnt", 64'(mif.result_cnt), 64'd4);
        ack_result();

        // stop in the start cycle is ignored; held stop gives 1
        mif.meas_start = 1'b1;
        mif.meas_stop  = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        chk("stop_at_start_vld", 64'(mif.result_vld), 64'd0);
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("held_stop_cnt", 64'(mif.result_cnt), 64'd1);

        // start edge while HOLD without ack -> lost_evt
        cyc_wait(1);
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        chk("lost_pulse", 64'(mif.lost_evt), 64'd1);
        cyc_wait(1);
        chk("lost_clear", 64'(mif.lost_evt),   64'd0);
        chk("lost_cnt",   64'(mif.result_cnt), 64'd1);
        chk("lost_vld",   64'(mif.result_vld), 64'd1);

        // ack and start edge together -> back-to-back measurement
        mif.result_ack = 1'b1;
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.result_ack = 1'b0;
        mif.meas_start = 1'b0;
        chk("b2b_busy", 64'(mif.busy),     64'd1);
        chk("b2b_lost", 64'(mif.lost_evt), 64'd0);
        cyc_wait(2);
        mif.meas_stop = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("b2b_cnt", 64'(mif.result_cnt), 64'd3);
        ack_result();

        // timeout_val changed mid-run: passed value never fires, later one does
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(5);
        mif.timeout_val = 32'd3;
        cyc_wait(3);
        chk("tv_passed_busy", 64'(mif.busy), 64'd1);
        mif.timeout_val = 32'd10;
        cyc_wait(2);
        chk("tv_live_cnt",  64'(mif.result_cnt),  64'd10);
        chk("tv_live_tout", 64'(mif.result_tout), 64'd1);
        ack_result();
        mif.timeout_val = '0;

        // saturation on the 4-bit meter
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(19);
        mif.meas_stop = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("sat4_cnt",  64'(mif4.result_cnt), 64'hF);
        chk("sat4_flag", 64'(mif4.result_sat), 64'd1);
        chk("sat4_vld",  64'(mif4.result_vld), 64'd1);
        chk("wide_cnt",  64'(mif.result_cnt),  64'd20);
        chk("wide_sat",  64'(mif.result_sat),  64'd0);
        ack_result();

        // async reset mid-RUN
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(2);
        #1;
        cpu_rst_b = 1'b0;
        #1;
        chk("arst_busy", 64'(mif.busy),        64'd0);
        chk("arst_vld",  64'(mif.result_vld),  64'd0);
        chk("arst_cnt",  64'(mif.result_cnt),  64'd0);
        chk("arst_tout", 64'(mif.result_tout), 64'd0);
        chk("arst_sat4", 64'(mif4.result_sat), 64'd0);
        cyc_wait(1);
        cpu_rst_b = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b1;
        cyc_wait(2);
        mif.meas_stop = 1'b0;
        chk("post_rst_stop_vld", 64'(mif.result_vld), 64'd0);
        mif.meas_start = 1'b1;
        cyc_wait(1);
        mif.meas_start = 1'b0;
        cyc_wait(2);
        mif.meas_stop = 1'b1;
        cyc_wait(1);
        mif.meas_stop = 1'b0;
        chk("post_rst_cnt", 64'(mif.result_cnt), 64'd3);
        ack_result();
        cyc_wait(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_interval_meter.md
Name: fifo_interval_meter

Overview:
- Measures the number of cpu_clk cycles between a start event and a stop event and returns the count through a valid/ack result handshake.
- It is the measuring counterpart of the countdown delay timer in the smart_run FIFO test infrastructure. The timer turns a loaded count into a delay; this block turns an observed delay back into a count.
- Used by bench FIFO models and checkers to measure request-to-response latency.
- Start detection uses the same rising-edge convention as the timer's enable.

Parameters:
- CNT_W, 32, width of the cycle counter, result_cnt and timeout_val.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst_b  in  1  reset; asynchronous, active-low.
- meas_start  in  1  level input; a rising edge (high now, low in the previous cycle) starts a measurement.
- meas_stop  in  1  level input; sampled high while RUN ends the measurement.
- timeout_val  in  CNT_W  cycle limit; 0 disables the timeout.
- result_ack  in  1  consumer acknowledge; effective only while result_vld=1.
- result_vld  out  1  a captured result is held.
- result_cnt  out  CNT_W  measured cycle count.
- result_tout  out  1  measurement ended by timeout, not by stop.
- result_sat  out  1  counter saturated at all-ones.
- busy  out  1  state is RUN.
- lost_evt  out  1  one-cycle pulse: a start edge was dropped while HOLD.

Behaviour:
- Reset (async assert, sync release) clears everything to 0:
  - state=IDLE; cnt=0; start_ff=0.
  - Outputs: result_vld=0, result_cnt=0, result_tout=0, result_sat=0, busy=0, lost_evt=0.
  - Reset mid-RUN or mid-HOLD discards the measurement; no result is produced.
- Edge detect: start_ff <= meas_start each cycle; start_edge = meas_start & ~start_ff.
- State machine:
  - IDLE:
    - start_edge -> RUN, cnt<=0.
    - meas_stop and result_ack are ignored in IDLE.
  - RUN (busy=1). At each edge, next = cnt+1, saturating at 2^CNT_W-1. Priority order:
    1. start_edge: restart. cnt<=0, stay RUN, no result.
    2. meas_stop: capture. result_cnt<=next, result_tout<=0, result_sat<=(cnt==all-ones or next==all-ones), result_vld<=1, -> HOLD.
    3. timeout_val!=0 and next==timeout_val: capture as in step 2 but with result_tout<=1, -> HOLD.
    4. Otherwise: cnt<=next.
  - HOLD (result_vld=1; result fields stable):
    - result_ack without start_edge -> IDLE, result_vld<=0. Result fields keep their last value.
    - result_ack with start_edge -> RUN, cnt<=0. Back-to-back measurement; the edge is not lost.
    - start_edge without result_ack: stay HOLD, lost_evt=1 for one cycle.
- Latency definition: start edge sampled at clock edge T, stop first sampled high at edge T+N (N>=1) -> result_cnt=N. result_vld rises at edge T+N.
- Simultaneous events:
  - meas_stop high in the same cycle as the start edge from IDLE: stop is ignored.
  - meas_stop held high continuously after start: result_cnt=1.
  - Stop and timeout in the same cycle: stop wins, result_tout=0.
- timeout_val is sampled live each cycle; changing it mid-RUN takes effect immediately.
- If next has already passed the new timeout_val, no timeout fires; counting continues to saturation.
- Saturation: cnt holds at all-ones and does not wrap. Any later capture reports all-ones with result_sat=1.
- result_ack while result_vld=0 has no effect.

Decomposition:
- Package fifo_meter_pkg holds:
  - State encoding localparams: IDLE=2'b00, RUN=2'b01, HOLD=2'b10. Encoding 2'b11 recovers to IDLE.
  - Saturating-increment function, parameterised on CNT_W.
- One sub-module, fifo_rise_det, holds the start_ff register and start_edge generation. It is reusable by the delay timer's enable logic.
- Counter, FSM and result registers live in the top module.

Test Plan:
- Basic: start rises at edge 10, stop pulses at edge 15, timeout_val=0 -> result_vld at edge 15 with result_cnt=5, tout=0, sat=0. Ack at edge 18 -> IDLE at edge 18.
- Timeout: timeout_val=8, start edge, no stop -> capture 8 cycles after the start edge: result_cnt=8, result_tout=1. Variant with stop in that same cycle -> result_tout=0, result_cnt=8.
- Restart: start edge, then start returns low and rises again 3 cycles later, then stop 4 cycles after the second edge -> result_cnt=4, one result only.
- HOLD interactions:
  - Start edge while HOLD without ack -> lost_evt one-cycle pulse; result_cnt unchanged.
  - Ack and start edge in the same cycle -> RUN; the next measurement is correct with no lost_evt.
- Saturation (CNT_W=4 build): start, no stop, timeout_val=0 for 20 cycles, then stop -> result_cnt=4'hF, result_sat=1.
- Reset mid-RUN: assert cpu_rst_b low asynchronously between clock edges during RUN -> all outputs 0 immediately. After release, stop alone produces no result; a fresh start/stop with N=3 yields result_cnt=3.
